// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the zerocpu core.
// Owns PC, IR and the retire counter, and times out stalled memory handshakes into HALT.
module core_seq_ctrl #(
  parameter logic [63:0] PC_RESET    = 64'h0000_0000_8000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] pc,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_rd_en,
  input  logic        dec_illegal,
  input  logic        dec_halt,
  input  logic [63:0] next_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rd_we,
  output logic        commit,
  output logic [63:0] inst_cnt,
  output logic        halted,
  output logic [1:0]  err_code
);

  // MEM and WB are split by access type / rd write so every strobe is a pure state decode.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5,
    S_WB_RD  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT - 1);
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  state_t      state;
  state_t      state_nx;
  logic [31:0] ir_nx;
  logic [63:0] pc_nx;
  logic [63:0] cnt_nx;
  logic [1:0]  err_nx;
  logic [31:0] wait_cnt;
  logic [31:0] wait_nx;
  logic        timeout_hit;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);

  // State, PC, IR, counters and error code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= PC_RESET;
      inst     <= NOP_INST;
      inst_cnt <= 64'd0;
      err_code <= 2'd0;
      wait_cnt <= 32'd0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      inst     <= ir_nx;
      inst_cnt <= cnt_nx;
      err_code <= err_nx;
      wait_cnt <= wait_nx;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nx = state;
    ir_nx    = inst;
    pc_nx    = pc;
    cnt_nx   = inst_cnt;
    err_nx   = err_code;
    wait_nx  = wait_cnt;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          ir_nx    = imem_rdata;
          state_nx = S_DECODE;
          wait_nx  = 32'd0;
        end else if (timeout_hit) begin
          err_nx   = 2'd2;
          state_nx = S_HALT;
          wait_nx  = 32'd0;
        end else begin
          wait_nx  = wait_cnt + 32'd1;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          err_nx   = 2'd1;
          state_nx = S_HALT;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        // Store takes priority so dmem_we follows dec_mem_wr when both are set.
        if (dec_mem_wr) begin
          state_nx = S_MEM_WR;
        end else if (dec_mem_rd) begin
          state_nx = S_MEM_RD;
        end else if (dec_rd_en) begin
          state_nx = S_WB_RD;
        end else begin
          state_nx = S_WB;
        end
        wait_nx = 32'd0;
      end
      S_MEM_RD, S_MEM_WR: begin
        if (dmem_ack) begin
          state_nx = dec_rd_en ? S_WB_RD : S_WB;
          wait_nx  = 32'd0;
        end else if (timeout_hit) begin
          err_nx   = 2'd2;
          state_nx = S_HALT;
          wait_nx  = 32'd0;
        end else begin
          wait_nx  = wait_cnt + 32'd1;
        end
      end
      S_WB, S_WB_RD: begin
        cnt_nx  = inst_cnt + 64'd1;
        wait_nx = 32'd0;
        if (next_pc[1:0] != 2'b00) begin
          err_nx   = 2'd3;
          state_nx = S_HALT;
        end else begin
          pc_nx    = next_pc;
          state_nx = dec_halt ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_HALT;
      end
    endcase
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (state == S_MEM_RD) || (state == S_MEM_WR);
  assign dmem_we   = (state == S_MEM_WR);
  assign rd_we     = (state == S_WB_RD);
  assign commit    = (state == S_WB) || (state == S_WB_RD);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl: a per-instruction timeline model predicts every
// cycle of the handshake, retire, error and halt behaviour.
module tb_core_seq_ctrl;
  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;
  localparam int          TO     = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        dec_mem_rd = 1'b0;
  logic        dec_mem_wr = 1'b0;
  logic        dec_rd_en = 1'b0;
  logic        dec_illegal = 1'b0;
  logic        dec_halt = 1'b0;
  logic [63:0] next_pc = 64'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rd_we;
  logic        commit;
  logic [63:0] inst_cnt;
  logic        halted;
  logic [1:0]  err_code;

  core_seq_ctrl #(.PC_RESET(PC_RST), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .pc(pc),
    .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_rd_en(dec_rd_en),
    .dec_illegal(dec_illegal), .dec_halt(dec_halt), .next_pc(next_pc),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rd_we(rd_we), .commit(commit), .inst_cnt(inst_cnt), .halted(halted), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] m_pc;
  logic [63:0] m_cnt;
  logic [31:0] m_ir;
  logic [1:0]  m_err;
  logic        m_halt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stray_acks();
    imem_ack = 1'($urandom);
    dmem_ack = 1'($urandom);
  endtask

  task automatic model_reset();
    m_pc = PC_RST; m_cnt = 64'd0; m_ir = 32'h0000_0013; m_err = 2'd0; m_halt = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
    tick(); tick();
    model_reset();
    @(negedge clk);
    check_val("rst_pc", pc, m_pc);
    check_val("rst_inst", inst, 64'(m_ir));
    check_val("rst_cnt", inst_cnt, m_cnt);
    check_val("rst_err", err_code, 64'(m_err));
    check_val("rst_strobes", {dmem_req, dmem_we, rd_we, commit, halted}, 64'd0);
    tick();
    rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  // Core is expected in HALT: everything frozen regardless of stray acks.
  task automatic check_halt();
    for (int k = 0; k < 4; k++) begin
      stray_acks();
      @(negedge clk);
      check_val("halt_flag", halted, 64'd1);
      check_val("halt_err", err_code, 64'(m_err));
      check_val("halt_pc", pc, m_pc);
      check_val("halt_inst", inst, 64'(m_ir));
      check_val("halt_cnt", inst_cnt, m_cnt);
      check_val("halt_strobes", {imem_req, dmem_req, rd_we, commit}, 64'd0);
      tick();
    end
  endtask

  // One instruction: iw/dw = cycles before imem/dmem ack (>= TO means never),
  // kind 0 alu, 1 load, 2 store; rst_mem >= 0 pulls reset in that MEM cycle together with an ack.
  task automatic do_instr(input int iw, input int dw, input int kind, input bit rd_en,
                          input bit illegal, input bit hlt, input logic [63:0] npc,
                          input int rst_mem);
    logic [31:0] word;
    word = $urandom;
    imem_rdata = word;
    dec_mem_rd = (kind == 1); dec_mem_wr = (kind == 2); dec_rd_en = rd_en;
    dec_illegal = illegal; dec_halt = hlt; next_pc = npc;
    for (int i = 0; i < TO; i++) begin
      imem_ack = (i == iw); dmem_ack = 1'($urandom);
      @(negedge clk);
      check_val("fetch_req", imem_req, 64'd1);
      check_val("fetch_addr", imem_addr, m_pc);
      check_val("fetch_cnt", inst_cnt, m_cnt);
      check_val("fetch_err", err_code, 64'(m_err));
      check_val("fetch_idle", {dmem_req, rd_we, commit, halted}, 64'd0);
      tick();
      if (i == iw) break;
      if (i == TO - 1) begin
        m_err = 2'd2; m_halt = 1'b1;
        check_halt();
        return;
      end
    end
    m_ir = word;
    stray_acks();
    @(negedge clk);
    check_val("dec_inst", inst, 64'(m_ir));
    check_val("dec_pc", pc, m_pc);
    check_val("dec_idle", {imem_req, dmem_req, rd_we, commit, halted}, 64'd0);
    tick();
    if (illegal) begin
      m_err = 2'd1; m_halt = 1'b1;
      check_halt();
      return;
    end
    stray_acks();
    @(negedge clk);
    check_val("exec_idle", {imem_req, dmem_req, rd_we, commit, halted}, 64'd0);
    tick();
    if (kind != 0) begin
      for (int j = 0; j < TO; j++) begin
        dmem_ack = (j == dw); imem_ack = 1'($urandom);
        if (j == rst_mem) begin
          rst_n = 1'b0; dmem_ack = 1'b1;
        end
        @(negedge clk);
        check_val("mem_req", {imem_req, dmem_req, rd_we, commit}, 64'b0100);
        check_val("mem_we", dmem_we, 64'(kind == 2));
        tick();
        if (j == rst_mem) begin
          model_reset();
          imem_ack = 1'b0; dmem_ack = 1'b0;
          @(negedge clk);
          check_val("mrst_pc", pc, m_pc);
          check_val("mrst_cnt", inst_cnt, m_cnt);
          check_val("mrst_state", {imem_req, dmem_req, rd_we, commit, halted}, 64'b10000);
          tick();
          rst_n = 1'b1;
          return;
        end
        if (j == dw) break;
        if (j == TO - 1) begin
          m_err = 2'd2; m_halt = 1'b1;
          check_halt();
          return;
        end
      end
    end
    stray_acks();
    @(negedge clk);
    check_val("wb_commit", commit, 64'd1);
    check_val("wb_rd_we", rd_we, 64'(rd_en));
    check_val("wb_idle", {imem_req, dmem_req, halted}, 64'd0);
    tick();
    m_cnt = m_cnt + 64'd1;
    if (npc[1:0] != 2'b00) begin
      m_err = 2'd3; m_halt = 1'b1;
    end else begin
      m_pc = npc; m_halt = hlt;
    end
    if (m_halt) check_halt();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, iw, dw, rm, nins;
    bit rd_en, ill, hlt;
    logic [63:0] npc;
    model_reset();
    do_reset();
    do_instr(0, 0, 0, 1'b1, 1'b0, 1'b0, m_pc + 64'd4, -1);
    check_val("t1_pc", m_pc, 64'h8000_0004);
    do_instr(0, 3, 1, 1'b1, 1'b0, 1'b0, m_pc + 64'd4, -1);
    do_instr(TO - 1, 0, 0, 1'b0, 1'b0, 1'b0, m_pc + 64'd4, -1);
    do_instr(0, 2, 2, 1'b0, 1'b0, 1'b0, m_pc + 64'd8, -1);
    do_instr(TO + 5, 0, 0, 1'b1, 1'b0, 1'b0, m_pc + 64'd4, -1);
    do_reset();
    do_instr(0, 0, 0, 1'b1, 1'b1, 1'b0, m_pc + 64'd4, -1);
    do_reset();
    do_instr(0, 0, 0, 1'b1, 1'b0, 1'b0, 64'h8000_0006, -1);
    do_reset();
    do_instr(0, TO + 5, 1, 1'b1, 1'b0, 1'b0, m_pc + 64'd4, -1);
    do_reset();
    do_instr(1, 5, 1, 1'b1, 1'b0, 1'b0, m_pc + 64'd4, 2);
    do_instr(0, 0, 0, 1'b1, 1'b0, 1'b1, m_pc + 64'd4, -1);
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      nins = 0;
      while (!m_halt && nins < 20) begin
        iw = $urandom_range(0, 3);
        if ($urandom_range(0, 19) == 0) iw = TO - 1;
        if ($urandom_range(0, 29) == 0) iw = TO + 3;
        dw = $urandom_range(0, 4);
        if ($urandom_range(0, 19) == 0) dw = TO - 1;
        if ($urandom_range(0, 29) == 0) dw = TO + 3;
        kind  = $urandom_range(0, 2);
        rd_en = 1'($urandom);
        ill   = ($urandom_range(0, 24) == 0);
        hlt   = ($urandom_range(0, 19) == 0);
        npc   = ($urandom_range(0, 3) == 0) ? {32'd0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC
                                            : m_pc + 64'd4;
        if ($urandom_range(0, 19) == 0) npc[1:0] = 2'($urandom_range(1, 3));
        rm = -1;
        if (kind != 0 && dw < TO && $urandom_range(0, 29) == 0) rm = $urandom_range(0, dw);
        do_instr(iw, dw, kind, rd_en, ill, hlt, npc, rm);
        nins++;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
